// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - default parameters and helper function for the fetch queue
// Contents: DEF_* parameter defaults shared by fetch_queue and sync_fifo,
//           clog2() used to size 0..N counters as clog2(N+1).
package fetch_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_INSTR_W  = 16;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_RESET_PC = 0;
    localparam int DEF_PC_INC   = 2;

    // Smallest r with 2**r >= n; a counter holding 0..N needs clog2(N+1) bits.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with flush, used for instructions and address tags
// Ports: clk, rst_n (async active-low), i_flush (drops all entries),
//        i_push/i_push_data (write), i_pop (read advance),
//        o_data (head entry), o_count (occupancy 0..DEPTH).
module sync_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    localparam int PW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    assign w_do_pop  = i_pop & (r_count != '0);
    assign w_do_push = i_push & ((r_count != CW'(DEPTH)) | w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue with credit-limited requests and redirect flush
// Ports: clk, rst_n (async active-low); halt, redirect_valid/redirect_pc (control);
//        imem_req_valid/imem_req_addr/imem_req_ready (fetch request);
//        imem_rsp_valid/imem_rsp_data (in-order response);
//        out_valid/out_instr/out_pc2/out_ready (decode side); halted, err (status).
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int RESET_PC = DEF_RESET_PC,
    parameter int PC_INC   = DEF_PC_INC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               halt,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc2,
    input  logic               out_ready,
    output logic               halted,
    output logic               err
);

    localparam int CW = clog2(DEPTH + 1);

    logic [ADDR_W-1:0]         r_fetch_pc;
    logic [CW-1:0]             r_outstanding;
    logic [CW-1:0]             r_discard;
    logic                      r_err;

    logic [ADDR_W-1:0]         w_pc_next;
    logic [CW:0]               w_inflight;
    logic                      w_req_valid;
    logic                      w_req_fire;
    logic                      w_rsp_match;
    logic                      w_rsp_keep;
    logic                      w_rsp_drop;
    logic                      w_pop;
    logic [CW-1:0]             w_q_count;
    logic [CW-1:0]             w_tag_count;
    logic [ADDR_W-1:0]         w_tag_head;
    logic [INSTR_W+ADDR_W-1:0] w_q_head;

    assign w_pc_next = r_fetch_pc + ADDR_W'(PC_INC);

    // Every outstanding request owns a queue slot, so responses can never overflow the queue.
    assign w_inflight  = {1'b0, r_outstanding} + {1'b0, w_q_count};
    assign w_req_valid = rst_n & !halt & !redirect_valid & (w_inflight < (CW+1)'(DEPTH));
    assign w_req_fire  = w_req_valid & imem_req_ready;

    // A response with nothing outstanding is spurious: flagged, never counted or queued.
    assign w_rsp_match = imem_rsp_valid & (r_outstanding != '0);
    assign w_rsp_drop  = w_rsp_match & (r_discard != '0);
    assign w_rsp_keep  = w_rsp_match & (r_discard == '0) & !redirect_valid & (w_tag_count != '0);

    assign out_valid = (w_q_count != '0) & !redirect_valid;
    assign w_pop     = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= ADDR_W'(RESET_PC);
            r_outstanding <= '0;
            r_discard     <= '0;
            r_err         <= 1'b0;
        end else begin
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_req_fire) begin
                r_fetch_pc <= w_pc_next;
            end

            case ({w_req_fire, w_rsp_match})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            // Everything still in flight after this cycle belongs to the abandoned stream.
            if (redirect_valid) begin
                r_discard <= r_outstanding - CW'(w_rsp_match);
            end else if (w_rsp_drop) begin
                r_discard <= r_discard - CW'(1);
            end

            if (imem_rsp_valid && (r_outstanding == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Tag FIFO carries pc + PC_INC of each live request, popped by its response.
    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (redirect_valid),
        .i_push      (w_req_fire),
        .i_push_data (w_pc_next),
        .i_pop       (w_rsp_keep),
        .o_data      (w_tag_head),
        .o_count     (w_tag_count)
    );

    sync_fifo #(
        .WIDTH (INSTR_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (redirect_valid),
        .i_push      (w_rsp_keep),
        .i_push_data ({imem_rsp_data, w_tag_head}),
        .i_pop       (w_pop),
        .o_data      (w_q_head),
        .o_count     (w_q_count)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign out_instr      = w_q_head[ADDR_W +: INSTR_W];
    assign out_pc2        = w_q_head[ADDR_W-1:0];
    assign halted         = rst_n & halt & (r_outstanding == '0);
    assign err            = r_err;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req_valid;
    logic [15:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        out_valid;
    logic [15:0] out_instr;
    logic [15:0] out_pc2;
    logic        out_ready;
    logic        halted;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;
    logic spur   = 1'b0;

    logic [15:0] pend_addr[$];
    int          pend_due[$];
    logic [15:0] req_log[$];
    logic [15:0] pop_pc2[$];
    logic [15:0] pop_instr[$];
    int          pop_cyc[$];

    fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc2        (out_pc2),
        .out_ready      (out_ready),
        .halted         (halted),
        .err            (err)
    );

    always #5 clk = ~clk;

    // One cycle: memory model drives a due response, then request/pop handshakes are logged.
    task automatic tick();
        if (spur) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 16'hDEAD;
        end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend_addr[0] + 16'h1000;
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 16'h0000;
        end
        #1;
        if (imem_req_valid && imem_req_ready) begin
            req_log.push_back(imem_req_addr);
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat);
        end
        if (out_valid && out_ready) begin
            pop_pc2.push_back(out_pc2);
            pop_instr.push_back(out_instr);
            pop_cyc.push_back(cyc);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'h0000;
        out_ready      = 1'b1;
        spur           = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        req_log.delete();
        pop_pc2.delete();
        pop_instr.delete();
        pop_cyc.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        halt           = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'h0000;
        out_ready      = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid);
        end
        checks++;
        if (imem_req_addr !== 16'h0000) begin
            failures++;
            $display("FAIL reset_pc got=%h exp=0000", imem_req_addr);
        end
        checks++;
        if ({out_valid, halted, err} !== 3'b000) begin
            failures++;
            $display("FAIL reset_status got=%b exp=000", {out_valid, halted, err});
        end
        checks++;
        if ({out_instr, out_pc2} !== 32'h0) begin
            failures++;
            $display("FAIL reset_head got=%h exp=00000000", {out_instr, out_pc2});
        end
    endtask

    task automatic test_sequential();
        do_reset();
        lat = 1;
        tick();
        checks++;
        if (req_log.size() !== 1) begin
            failures++;
            $display("FAIL first_req_cycle got=%0d reqs exp=1", req_log.size());
        end
        repeat (11) tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (req_log[i] !== 16'(2 * i)) begin
                failures++;
                $display("FAIL seq_req_addr[%0d] got=%h exp=%h", i, req_log[i], 16'(2 * i));
            end
            checks++;
            if (pop_pc2[i] !== 16'(2 * i + 2) || pop_instr[i] !== 16'(16'h1000 + 2 * i)) begin
                failures++;
                $display("FAIL seq_pop[%0d] got=%h/%h exp=%h/%h", i, pop_pc2[i], pop_instr[i],
                         16'(2 * i + 2), 16'(16'h1000 + 2 * i));
            end
        end
        checks++;
        if (pop_cyc[0] !== 2) begin
            failures++;
            $display("FAIL rsp_to_out_latency got=cycle %0d exp=cycle 2", pop_cyc[0]);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat       = 1;
        out_ready = 1'b0;
        repeat (10) tick();
        checks++;
        if (req_log.size() !== 4 || imem_req_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_credit got=%0d reqs valid=%b exp=4 reqs valid=0",
                     req_log.size(), imem_req_valid);
        end
        checks++;
        if (out_valid !== 1'b1 || out_pc2 !== 16'h0002) begin
            failures++;
            $display("FAIL bp_head got=%b/%h exp=1/0002", out_valid, out_pc2);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0008) begin
            failures++;
            $display("FAIL bp_resume got=%b/%h exp=1/0008", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        lat = 3;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0100;
        tick();
        redirect_valid = 1'b0;
        checks++;
        if (req_log.size() !== 3) begin
            failures++;
            $display("FAIL redir_blocks_req got=%0d reqs exp=3", req_log.size());
        end
        repeat (12) tick();
        checks++;
        if (req_log.size() < 4 || req_log[3] !== 16'h0100) begin
            failures++;
            $display("FAIL redir_target got=%0d reqs exp=req[3]=0100", req_log.size());
        end
        checks++;
        if (pop_pc2.size() < 1 || pop_pc2[0] !== 16'h0102 || pop_instr[0] !== 16'h1100) begin
            failures++;
            $display("FAIL redir_first_out got=%0d pops exp=0102/1100", pop_pc2.size());
        end
        checks++;
        if (pop_cyc.size() < 1 || pop_cyc[0] !== 8) begin
            failures++;
            $display("FAIL redir_first_out_cycle got=%0d pops exp=cycle 8", pop_cyc.size());
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL redir_no_err got=%b exp=0", err);
        end
    endtask

    task automatic test_halt();
        do_reset();
        lat = 3;
        repeat (2) tick();
        halt = 1'b1;
        repeat (2) tick();
        checks++;
        if (halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_pending got=%b exp=0", halted);
        end
        tick();
        checks++;
        if (halted !== 1'b1) begin
            failures++;
            $display("FAIL halt_done got=%b exp=1", halted);
        end
        repeat (4) tick();
        checks++;
        if (req_log.size() !== 2 || pop_pc2.size() !== 2) begin
            failures++;
            $display("FAIL halt_drain got=%0d reqs %0d pops exp=2 reqs 2 pops",
                     req_log.size(), pop_pc2.size());
        end
        checks++;
        if (pop_pc2.size() == 2 && (pop_pc2[0] !== 16'h0002 || pop_pc2[1] !== 16'h0004)) begin
            failures++;
            $display("FAIL halt_drain_order got=%h,%h exp=0002,0004", pop_pc2[0], pop_pc2[1]);
        end
        halt = 1'b0;
        tick();
        checks++;
        if (req_log.size() !== 3 || req_log[req_log.size() - 1] !== 16'h0004 || halted !== 1'b0) begin
            failures++;
            $display("FAIL halt_release got=%0d reqs halted=%b exp=3 reqs last=0004 halted=0",
                     req_log.size(), halted);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        lat            = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFC;
        tick();
        redirect_valid = 1'b0;
        repeat (8) tick();
        checks++;
        if (req_log[0] !== 16'hFFFC || req_log[1] !== 16'hFFFE || req_log[2] !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_req got=%h,%h,%h exp=fffc,fffe,0000",
                     req_log[0], req_log[1], req_log[2]);
        end
        checks++;
        if (pop_pc2[1] !== 16'h0000 || pop_instr[1] !== 16'h0FFE) begin
            failures++;
            $display("FAIL wrap_pc2 got=%h/%h exp=0000/0ffe", pop_pc2[1], pop_instr[1]);
        end
    endtask

    task automatic test_err();
        do_reset();
        lat            = 1;
        imem_req_ready = 1'b0;
        tick();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_idle got=%b exp=0", err);
        end
        spur = 1'b1;
        tick();
        spur = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_set got=%b exp=1", err);
        end
        imem_req_ready = 1'b1;
        repeat (6) tick();
        checks++;
        if (err !== 1'b1 || pop_pc2.size() == 0) begin
            failures++;
            $display("FAIL err_sticky got=%b pops=%0d exp=1 pops>0", err, pop_pc2.size());
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({err, out_valid, imem_req_valid} !== 3'b000 || imem_req_addr !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset got=%b/%h exp=000/0000",
                     {err, out_valid, imem_req_valid}, imem_req_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
